// File: rtl/dec_op_ctrl_bank_pkg.sv
// ============================================================================
// Module      : dec_op_ctrl_bank_pkg
// Description : Shared constants, types and address helper for the control bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dec_op_ctrl_bank_pkg;

    localparam int C_CH_STRIDE = 4;
    localparam int C_HI_OFFSET = 2;
    localparam int C_HALF_W    = 16;
    localparam int C_WORD_W    = 32;

    localparam logic [25:0] C_DEF_BASE_ADDR = 26'h2000104;

    typedef logic [C_HALF_W-1:0] half_t;
    typedef logic [C_WORD_W-1:0] word_t;

    // Byte address of a channel's low (hi=0) or high (hi=1) half-word.
    function automatic logic [31:0] chan_addr(input logic [31:0] base,
                                              input int unsigned ch,
                                              input logic hi);
        return base + 32'(ch * C_CH_STRIDE) + (hi ? 32'(C_HI_OFFSET) : 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dec_op_ctrl_chan.sv
// ============================================================================
// Module      : dec_op_ctrl_chan
// Description : One control channel: low holding, shadow, pending flag, active word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_op_ctrl_chan
    import dec_op_ctrl_bank_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_lo_wr,
    input  logic  i_hi_wr,
    input  logic  i_commit,
    input  half_t i_data,
    output word_t o_active,
    output logic  o_upd,
    output logic  o_pend,
    output logic  o_pend_nxt
);

    half_t r_lo;
    word_t r_shadow;
    word_t r_active;
    logic  r_pend;
    logic  r_upd;
    logic  w_pend_nxt;

    // A new high write keeps the channel pending even while the old shadow commits.
    assign w_pend_nxt = i_hi_wr | (r_pend & ~i_commit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo     <= '0;
            r_shadow <= '0;
            r_active <= '0;
            r_pend   <= 1'b0;
            r_upd    <= 1'b0;
        end else begin
            if (i_lo_wr) begin
                r_lo <= i_data;
            end
            if (i_hi_wr) begin
                r_shadow <= {i_data, r_lo};
            end
            if (i_commit) begin
                r_active <= r_shadow;
            end
            r_upd  <= i_commit;
            r_pend <= w_pend_nxt;
        end
    end

    assign o_active   = r_active;
    assign o_upd      = r_upd;
    assign o_pend     = r_pend;
    assign o_pend_nxt = w_pend_nxt;

endmodule

`default_nettype wire

// File: rtl/dec_op_ctrl_bank.sv
// ============================================================================
// Module      : dec_op_ctrl_bank
// Description : Bank of NUM_CH double-buffered 32-bit control words written as
//               16-bit halves; optional readback enabled by DEC_OP_CTRL_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_op_ctrl_bank
    import dec_op_ctrl_bank_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                ADDR_W      = 26,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(C_DEF_BASE_ADDR),
    parameter int                AUTO_COMMIT = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [ADDR_W-1:0]    ADDR_IN,
    input  logic [15:0]          DATA_IN,
    input  logic                 WR_EN,
`ifdef DEC_OP_CTRL_READBACK_EN
    input  logic                 RD_EN,
    output logic [15:0]          RD_DATA,
    output logic                 RD_VALID,
`endif
    output logic [NUM_CH*32-1:0] CTRL_OUT,
    output logic [NUM_CH-1:0]    CTRL_UPD,
    output logic                 PEND
);

    localparam logic [ADDR_W-1:0] C_COMMIT_ADDR =
        ADDR_W'(chan_addr(32'(BASE_ADDR), NUM_CH, 1'b0));

    logic [NUM_CH-1:0]    w_lo_wr;
    logic [NUM_CH-1:0]    w_hi_wr;
    logic [NUM_CH-1:0]    w_commit;
    logic [NUM_CH-1:0]    w_pend;
    logic [NUM_CH-1:0]    w_pend_nxt;
    logic [NUM_CH*32-1:0] w_active;
    logic                 w_commit_wr;
    logic                 r_pend_any;

    assign w_commit_wr = WR_EN && (ADDR_IN == C_COMMIT_ADDR);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        localparam logic [ADDR_W-1:0] C_LO_ADDR = ADDR_W'(chan_addr(32'(BASE_ADDR), n, 1'b0));
        localparam logic [ADDR_W-1:0] C_HI_ADDR = ADDR_W'(chan_addr(32'(BASE_ADDR), n, 1'b1));

        assign w_lo_wr[n]  = WR_EN && (ADDR_IN == C_LO_ADDR);
        assign w_hi_wr[n]  = WR_EN && (ADDR_IN == C_HI_ADDR);
        // Auto mode: a pending shadow always commits on the following edge.
        assign w_commit[n] = (AUTO_COMMIT != 0) ? w_pend[n]
                                                : (w_commit_wr && DATA_IN[n] && w_pend[n]);

        dec_op_ctrl_chan u_chan (
            .clk        (Clock),
            .rst        (Reset),
            .i_lo_wr    (w_lo_wr[n]),
            .i_hi_wr    (w_hi_wr[n]),
            .i_commit   (w_commit[n]),
            .i_data     (DATA_IN),
            .o_active   (w_active[32*n +: 32]),
            .o_upd      (CTRL_UPD[n]),
            .o_pend     (w_pend[n]),
            .o_pend_nxt (w_pend_nxt[n])
        );
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pend_any <= 1'b0;
        end else begin
            r_pend_any <= |w_pend_nxt;
        end
    end

    assign CTRL_OUT = w_active;
    assign PEND     = r_pend_any;

`ifdef DEC_OP_CTRL_READBACK_EN
    logic [15:0] w_rd_mux;
    logic [15:0] r_rd_data;
    logic        r_rd_valid;

    always_comb begin
        w_rd_mux = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (ADDR_IN == ADDR_W'(chan_addr(32'(BASE_ADDR), n, 1'b0))) begin
                w_rd_mux = w_active[32*n +: 16];
            end
            if (ADDR_IN == ADDR_W'(chan_addr(32'(BASE_ADDR), n, 1'b1))) begin
                w_rd_mux = w_active[32*n+16 +: 16];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_data  <= RD_EN ? w_rd_mux : 16'h0000;
            r_rd_valid <= RD_EN;
        end
    end

    assign RD_DATA  = r_rd_data;
    assign RD_VALID = r_rd_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dec_op_ctrl_bank.sv
// ============================================================================
// Module      : tb_dec_op_ctrl_bank
// Description : Directed self-checking bench driving an AUTO_COMMIT=1 and an
//               AUTO_COMMIT=0 instance from the same write bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_op_ctrl_bank;

    localparam logic [25:0] B      = 26'h2000104;
    localparam logic [25:0] LO0    = B + 26'd0;
    localparam logic [25:0] HI0    = B + 26'd2;
    localparam logic [25:0] LO1    = B + 26'd4;
    localparam logic [25:0] HI1    = B + 26'd6;
    localparam logic [25:0] LO2    = B + 26'd8;
    localparam logic [25:0] HI2    = B + 26'd10;
    localparam logic [25:0] LO3    = B + 26'd12;
    localparam logic [25:0] HI3    = B + 26'd14;
    localparam logic [25:0] COMMIT = B + 26'd16;
    localparam logic [25:0] UNMAP  = B + 26'd24;

    logic         Clock = 1'b0;
    logic         Reset;
    logic [25:0]  ADDR_IN;
    logic [15:0]  DATA_IN;
    logic         WR_EN;
    logic [127:0] ca, cm;
    logic [3:0]   ua, um;
    logic         pa, pm;
    int           checks   = 0;
    int           failures = 0;

`ifdef DEC_OP_CTRL_READBACK_EN
    logic        rd_en = 1'b0;
    logic [15:0] rd_data_a, rd_data_m;
    logic        rd_valid_a, rd_valid_m;
`endif

    always #5 Clock = ~Clock;

    dec_op_ctrl_bank #(.AUTO_COMMIT(1)) u_auto (
        .Clock (Clock), .Reset (Reset), .ADDR_IN (ADDR_IN), .DATA_IN (DATA_IN), .WR_EN (WR_EN),
`ifdef DEC_OP_CTRL_READBACK_EN
        .RD_EN (rd_en), .RD_DATA (rd_data_a), .RD_VALID (rd_valid_a),
`endif
        .CTRL_OUT (ca), .CTRL_UPD (ua), .PEND (pa)
    );

    dec_op_ctrl_bank #(.AUTO_COMMIT(0)) u_man (
        .Clock (Clock), .Reset (Reset), .ADDR_IN (ADDR_IN), .DATA_IN (DATA_IN), .WR_EN (WR_EN),
`ifdef DEC_OP_CTRL_READBACK_EN
        .RD_EN (rd_en), .RD_DATA (rd_data_m), .RD_VALID (rd_valid_m),
`endif
        .CTRL_OUT (cm), .CTRL_UPD (um), .PEND (pm)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [25:0] a, input logic [15:0] d);
        @(negedge Clock);
        ADDR_IN = a;
        DATA_IN = d;
        WR_EN   = 1'b1;
        @(negedge Clock);
        WR_EN   = 1'b0;
    endtask

    logic [127:0] ea, em;

    initial begin
        Reset   = 1'b1;
        ADDR_IN = '0;
        DATA_IN = '0;
        WR_EN   = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        chk("rst_ctrl_a", ca, 128'h0);
        chk("rst_ctrl_m", cm, 128'h0);
        chk("rst_upd_a", 128'(ua), 128'h0);
        chk("rst_upd_m", 128'(um), 128'h0);
        chk("rst_pend_a", 128'(pa), 128'h0);
        chk("rst_pend_m", 128'(pm), 128'h0);

        // Channel 0: low then high; auto commits two edges after the high write
        wr(LO0, 16'h5678);
        wr(HI0, 16'h1234);
        chk("ch0_shadow_ctrl_a", ca, 128'h0);
        chk("ch0_shadow_pend_a", 128'(pa), 128'h1);
        chk("ch0_shadow_pend_m", 128'(pm), 128'h1);
        @(negedge Clock);
        ea = {96'h0, 32'h12345678};
        chk("ch0_commit_ctrl_a", ca, ea);
        chk("ch0_commit_upd_a", 128'(ua), 128'h1);
        chk("ch0_commit_pend_a", 128'(pa), 128'h0);
        chk("ch0_hold_ctrl_m", cm, 128'h0);
        chk("ch0_hold_pend_m", 128'(pm), 128'h1);
        @(negedge Clock);
        chk("ch0_upd_pulse_a", 128'(ua), 128'h0);

        wr(COMMIT, 16'h0001);
        em = {96'h0, 32'h12345678};
        chk("ch0_commit_ctrl_m", cm, em);
        chk("ch0_commit_upd_m", 128'(um), 128'h1);
        chk("ch0_commit_pend_m", 128'(pm), 128'h0);
        chk("ignore_commit_upd_a", 128'(ua), 128'h0);

        // Channels 1 and 2 committed together in manual mode
        wr(LO1, 16'h5555);
        wr(HI1, 16'hAAAA);
        wr(LO2, 16'h0F0F);
        wr(HI2, 16'h0F0F);
        chk("ch12_pend_m", 128'(pm), 128'h1);
        chk("ch12_nochange_m", cm, em);
        wr(COMMIT, 16'h0006);
        em = {32'h0, 32'h0F0F0F0F, 32'hAAAA5555, 32'h12345678};
        ea = em;
        chk("ch12_commit_ctrl_m", cm, em);
        chk("ch12_commit_upd_m", 128'(um), 128'h6);
        chk("ch12_commit_pend_m", 128'(pm), 128'h0);
        chk("ch12_ctrl_a", ca, ea);
        chk("ch12_upd_a", 128'(ua), 128'h0);
        chk("ch12_pend_a", 128'(pa), 128'h0);

        wr(COMMIT, 16'h0001);
        chk("nopend_commit_ctrl_m", cm, em);
        chk("nopend_commit_upd_m", 128'(um), 128'h0);

        // Reset mid-sequence discards the low write; writes during reset are ignored
        wr(LO3, 16'hBEEF);
        @(negedge Clock);
        Reset   = 1'b1;
        ADDR_IN = LO3;
        DATA_IN = 16'h1111;
        WR_EN   = 1'b1;
        @(negedge Clock);
        Reset   = 1'b0;
        WR_EN   = 1'b0;
        chk("midrst_ctrl_a", ca, 128'h0);
        chk("midrst_ctrl_m", cm, 128'h0);
        chk("midrst_pend_a", 128'(pa), 128'h0);
        chk("midrst_pend_m", 128'(pm), 128'h0);
        wr(HI3, 16'h0001);
        chk("ch3_pend_m", 128'(pm), 128'h1);
        @(negedge Clock);
        ea = {32'h00010000, 96'h0};
        chk("ch3_ctrl_a", ca, ea);
        chk("ch3_upd_a", 128'(ua), 128'h8);
        wr(COMMIT, 16'h0008);
        em = ea;
        chk("ch3_ctrl_m", cm, em);
        chk("ch3_upd_m", 128'(um), 128'h8);

        // Unmapped write and WR_EN low writes change nothing
        wr(UNMAP, 16'hFFFF);
        @(negedge Clock);
        ADDR_IN = HI0;
        DATA_IN = 16'hFFFF;
        WR_EN   = 1'b0;
        @(negedge Clock);
        ADDR_IN = LO1;
        repeat (2) @(negedge Clock);
        chk("unmap_ctrl_a", ca, ea);
        chk("unmap_ctrl_m", cm, em);
        chk("unmap_pend_a", 128'(pa), 128'h0);
        chk("unmap_pend_m", 128'(pm), 128'h0);
        chk("unmap_upd_a", 128'(ua), 128'h0);
        wr(COMMIT, 16'hFFFF);
        chk("highmask_ctrl_m", cm, em);
        chk("highmask_upd_m", 128'(um), 128'h0);

        // Back-to-back high writes to ch1: old shadow commits, new one stays pending
        @(negedge Clock);
        ADDR_IN = HI1;
        DATA_IN = 16'h2222;
        WR_EN   = 1'b1;
        @(negedge Clock);
        DATA_IN = 16'h3333;
        @(negedge Clock);
        WR_EN   = 1'b0;
        chk("b2b_first_ctrl_a", ca, {32'h00010000, 32'h0, 32'h22220000, 32'h0});
        chk("b2b_first_pend_a", 128'(pa), 128'h1);
        @(negedge Clock);
        chk("b2b_second_ctrl_a", ca, {32'h00010000, 32'h0, 32'h33330000, 32'h0});
        chk("b2b_second_upd_a", 128'(ua), 128'h2);
        chk("b2b_second_pend_a", 128'(pa), 128'h0);
        wr(COMMIT, 16'h0002);
        chk("b2b_ctrl_m", cm, {32'h00010000, 32'h0, 32'h33330000, 32'h0});
        chk("b2b_upd_m", 128'(um), 128'h2);

        repeat (3) @(negedge Clock);
        chk("hold_ctrl_m", cm, {32'h00010000, 32'h0, 32'h33330000, 32'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
